// File: rtl/card_dealer.sv
// Card source for the blackjack controller: deals one card per request from a
// tracked 52-card shoe (four of each rank), with no repeats until a reshuffle.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          MAX_TRIES      = 8,
  parameter bit          AUTO_RESHUFFLE = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       card_req,
  input  logic       shuffle,
  output logic       busy,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [3:0] card_points,
  output logic       is_ace,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       draw_err
);

  typedef enum logic [2:0] {IDLE, REFILL, DRAW, SCAN, DELIVER} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [2:0]  cnt [0:12];
  logic [7:0]  tries;

  logic [3:0]  cand;
  logic        cand_hit;
  logic [3:0]  scan_idx;
  logic        refill_now;
  logic        take_now;
  logic [3:0]  take_idx;
  logic [3:0]  take_rank;

  function automatic logic [3:0] points_of(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd10 : rank;
  endfunction

  assign cand       = lfsr[3:0];
  assign deck_empty = (cards_left == 6'd0);
  assign take_rank  = take_idx + 4'd1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cand_hit = 1'b0;
    if (cand < 4'd13) cand_hit = (cnt[cand] != 3'd0);
  end

  // Lowest nonzero rank wins: scan downward so the last assignment is the lowest.
  always_comb begin
    scan_idx = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (cnt[i] != 3'd0) scan_idx = 4'(i);
    end
  end

  // A shuffle refills in every state; it also wins over a same-cycle take.
  always_comb begin
    refill_now = shuffle || (state == REFILL);
    take_now   = !shuffle && (((state == DRAW) && cand_hit) || (state == SCAN));
    take_idx   = (state == SCAN) ? scan_idx : cand;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // NOTE: the rank counters are plain flops, not a RAM, so resetting them to a full shoe is cheap and safe.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 13; i++) cnt[i] <= 3'd4;
      cards_left <= 6'd52;
    end else if (refill_now) begin
      for (int i = 0; i < 13; i++) cnt[i] <= 3'd4;
      cards_left <= 6'd52;
    end else if (take_now) begin
      cnt[take_idx] <= cnt[take_idx] - 3'd1;
      cards_left    <= cards_left - 6'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tries       <= 8'd0;
      busy        <= 1'b0;
      card_valid  <= 1'b0;
      draw_err    <= 1'b0;
      card_rank   <= 4'd0;
      card_points <= 4'd0;
      is_ace      <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      draw_err   <= 1'b0;
      if (take_now) begin
        card_rank   <= take_rank;
        card_points <= points_of(take_rank);
        is_ace      <= (take_idx == 4'd0);
      end
      case (state)
        IDLE: begin
          if (card_req) begin
            if (shuffle || cards_left != 6'd0) begin
              state <= DRAW;
              tries <= 8'd0;
              busy  <= 1'b1;
            end else if (AUTO_RESHUFFLE) begin
              state <= REFILL;
              busy  <= 1'b1;
            end else begin
              draw_err <= 1'b1;
            end
          end
        end
        REFILL: begin
          tries <= 8'd0;
          if (shuffle) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DRAW;
          end
        end
        DRAW: begin
          if (shuffle) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cand_hit) begin
            state      <= DELIVER;
            card_valid <= 1'b1;
          end else if (tries == 8'(MAX_TRIES)) begin
            state <= SCAN;
          end else begin
            tries <= tries + 8'd1;
          end
        end
        SCAN: begin
          if (shuffle) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= DELIVER;
            card_valid <= 1'b1;
          end
        end
        DELIVER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: one auto-reshuffle instance and one with
// MAX_TRIES=1 / no auto-reshuffle, checked against a per-rank shoe model.
module tb_card_dealer;

  typedef struct {
    int d;
    int exp_left;
    int min_lat;
    int max_lat;
  } exp_t;

  localparam int MT [2] = '{8, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic       req    [2];
  logic       shf    [2];
  logic       busy   [2];
  logic       valid  [2];
  logic [3:0] rank   [2];
  logic [3:0] pts    [2];
  logic       ace    [2];
  logic [5:0] left   [2];
  logic       empty  [2];
  logic       err    [2];

  int   cm   [2][13];
  int   ml   [2];
  int   vcnt [2];
  int   ecnt [2];
  exp_t sb   [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #10 clk = ~clk;

  card_dealer dut0 (
    .CLOCK_50(clk), .reset(reset), .card_req(req[0]), .shuffle(shf[0]),
    .busy(busy[0]), .card_valid(valid[0]), .card_rank(rank[0]),
    .card_points(pts[0]), .is_ace(ace[0]), .cards_left(left[0]),
    .deck_empty(empty[0]), .draw_err(err[0])
  );

  card_dealer #(.MAX_TRIES(1), .AUTO_RESHUFFLE(1'b0)) dut1 (
    .CLOCK_50(clk), .reset(reset), .card_req(req[1]), .shuffle(shf[1]),
    .busy(busy[1]), .card_valid(valid[1]), .card_rank(rank[1]),
    .card_points(pts[1]), .is_ace(ace[1]), .cards_left(left[1]),
    .deck_empty(empty[1]), .draw_err(err[1])
  );

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (valid[d]) vcnt[d]++;
      if (err[d])   ecnt[d]++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int exp_pts(input int r);
    return (r >= 10) ? 10 : r;
  endfunction

  function automatic int lowest(input int d);
    for (int k = 0; k < 13; k++) if (cm[d][k] > 0) return k + 1;
    return 0;
  endfunction

  task automatic fill_model(input int d);
    for (int k = 0; k < 13; k++) cm[d][k] = 4;
    ml[d] = 52;
  endtask

  // One request; extra_req re-pulses card_req while the dealer is busy.
  task automatic draw(input int d, input bit extra_req);
    exp_t e;
    int   lat;
    int   r;
    bit   refill;
    refill = (ml[d] == 0);
    if (refill) fill_model(d);
    ml[d]--;
    e.d = d;
    e.exp_left = ml[d];
    e.min_lat = 2 + int'(refill);
    e.max_lat = MT[d] + 3 + int'(refill);
    sb.push_back(e);
    @(negedge clk); req[d] = 1'b1;
    @(negedge clk); req[d] = extra_req; lat = 1;
    check($sformatf("d%0d_busy", d), busy[d], 1);
    while (!valid[d] && lat < 40) begin
      @(negedge clk); req[d] = 1'b0; lat++;
    end
    e = sb.pop_front();
    if (!valid[d]) begin
      check($sformatf("d%0d_timeout", e.d), 0, 1);
      return;
    end
    check($sformatf("d%0d_lat_min", e.d), int'(lat >= e.min_lat), 1);
    check($sformatf("d%0d_lat_max", e.d), int'(lat <= e.max_lat), 1);
    check($sformatf("d%0d_left", e.d), left[d], e.exp_left);
    r = rank[d];
    check($sformatf("d%0d_points", d), pts[d], exp_pts(r));
    check($sformatf("d%0d_is_ace", d), ace[d], int'(r == 1));
    check($sformatf("d%0d_rank_range", d), int'(r >= 1 && r <= 13), 1);
    if (r >= 1 && r <= 13) begin
      check($sformatf("d%0d_rank_avail", d), int'(cm[d][r-1] > 0), 1);
      if (lat == e.max_lat) check($sformatf("d%0d_scan_lowest", d), r, lowest(d));
      if (cm[d][r-1] > 0) cm[d][r-1]--;
    end
    @(negedge clk);
    check($sformatf("d%0d_valid_pulse", d), valid[d], 0);
    check($sformatf("d%0d_rank_held", d), rank[d], r);
  endtask

  task automatic drain(input int d);
    int v0;
    v0 = vcnt[d];
    for (int i = 0; i < 52; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      draw(d, 1'b0);
    end
    check($sformatf("d%0d_valid_count", d), vcnt[d] - v0, 52);
    check($sformatf("d%0d_left_zero", d), left[d], 0);
    check($sformatf("d%0d_deck_empty", d), empty[d], 1);
    for (int k = 0; k < 13; k++) check($sformatf("d%0d_rank%0d_four", d, k + 1), cm[d][k], 0);
  endtask

  initial begin
    int v0;
    int e0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; shf[d] = 1'b0; vcnt[d] = 0; ecnt[d] = 0;
      fill_model(d);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_rank", d), rank[d], 0);
      check($sformatf("d%0d_rst_points", d), pts[d], 0);
      check($sformatf("d%0d_rst_ace", d), ace[d], 0);
      check($sformatf("d%0d_rst_busy", d), busy[d], 0);
      check($sformatf("d%0d_rst_valid", d), valid[d], 0);
      check($sformatf("d%0d_rst_err", d), err[d], 0);
      check($sformatf("d%0d_rst_left", d), left[d], 52);
      check($sformatf("d%0d_rst_empty", d), empty[d], 0);
    end

    // Full shoe on each instance, then auto-reshuffle on the empty one.
    drain(0);
    draw(0, 1'b0);
    check("d0_left_after_refill", left[0], 51);
    drain(1);

    // Empty shoe without auto-reshuffle: rejected with a single draw_err.
    v0 = vcnt[1]; e0 = ecnt[1];
    @(negedge clk); req[1] = 1'b1;
    @(negedge clk); req[1] = 1'b0;
    check("d1_err_pulse", err[1], 1);
    check("d1_err_busy", busy[1], 0);
    @(negedge clk);
    check("d1_err_single", err[1], 0);
    repeat (8) @(negedge clk);
    check("d1_err_busy_later", busy[1], 0);
    check("d1_err_count", ecnt[1] - e0, 1);
    check("d1_err_no_card", vcnt[1] - v0, 0);
    check("d1_err_left", left[1], 0);

    // Shuffle while idle refills next cycle.
    @(negedge clk); shf[1] = 1'b1;
    @(negedge clk); shf[1] = 1'b0;
    check("d1_shuffle_left", left[1], 52);
    check("d1_shuffle_empty", empty[1], 0);
    fill_model(1);

    // Shuffle the cycle after acceptance aborts the draw.
    v0 = vcnt[0];
    @(negedge clk); req[0] = 1'b1;
    @(negedge clk); req[0] = 1'b0; shf[0] = 1'b1;
    @(negedge clk); shf[0] = 1'b0;
    check("d0_abort_left", left[0], 52);
    check("d0_abort_busy", busy[0], 0);
    repeat (10) @(negedge clk);
    check("d0_abort_no_card", vcnt[0] - v0, 0);
    fill_model(0);

    // A second request while busy is dropped.
    v0 = vcnt[0];
    draw(0, 1'b1);
    repeat (10) @(negedge clk);
    check("d0_busy_req_one_card", vcnt[0] - v0, 1);
    check("d0_busy_req_left", left[0], 51);

    // Async reset in the middle of a draw.
    v0 = vcnt[0];
    @(negedge clk); req[0] = 1'b1;
    @(negedge clk); req[0] = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("d0_midrst_busy", busy[0], 0);
    check("d0_midrst_valid", valid[0], 0);
    check("d0_midrst_rank", rank[0], 0);
    check("d0_midrst_points", pts[0], 0);
    check("d0_midrst_ace", ace[0], 0);
    check("d0_midrst_left", left[0], 52);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    check("d0_midrst_no_card", vcnt[0] - v0, 0);
    check("d0_midrst_idle", busy[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
